// File: rtl/ws2812b_meter_pkg.sv
// Shared definitions for the WS2812B level-meter blocks: FSM encoding,
// multiplier step count and the datapath widths used across the slice.
package ws2812b_meter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      MAP    = 2'd2,
      UPDATE = 2'd3
   } meterState_t;

   localparam int MAP_STEPS = 16;
   localparam int MAG_W     = 15;
   localparam int LVL_W     = 16;
   localparam int PROD_W    = MAG_W + LVL_W;

endpackage

// File: rtl/ws2812b_meter_mul16.sv
// Sequential shift-add multiplier, 15x16 -> 31 bits, one multiplier bit per
// clock; done is high during the final step so the caller can leave on that edge.
module ws2812b_meter_mul16
   import ws2812b_meter_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              start,
   input  logic [MAG_W-1:0]  multiplicand,
   input  logic [LVL_W-1:0]  multiplier,
   output logic              busy,
   output logic              done,
   output logic [PROD_W-1:0] product
);

   logic [PROD_W-1:0] mcandSh;
   logic [LVL_W-1:0]  mplierSh;
   logic [3:0]        stepCnt;

   assign done = busy && (stepCnt == 4'(MAP_STEPS - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy     <= 1'b0;
         stepCnt  <= '0;
         mcandSh  <= '0;
         mplierSh <= '0;
         product  <= '0;
      end else if (clear) begin
         busy     <= 1'b0;
         stepCnt  <= '0;
         mcandSh  <= '0;
         mplierSh <= '0;
         product  <= '0;
      end else if (start) begin
         busy     <= 1'b1;
         stepCnt  <= '0;
         mcandSh  <= {{(PROD_W-MAG_W){1'b0}}, multiplicand};
         mplierSh <= multiplier;
         product  <= '0;
      end else if (busy) begin
         if (mplierSh[0]) begin
            product <= product + mcandSh;
         end
         mcandSh  <= mcandSh << 1;
         mplierSh <= mplierSh >> 1;
         stepCnt  <= stepCnt + 4'd1;
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ws2812b_meter_level.sv
// Audio level meter for a WS2812B strip: windowed peak detect, scaling to the
// LED count, attack/decay of the lit bar and a held peak marker.
module ws2812b_meter_level
   import ws2812b_meter_pkg::*;
#(
   parameter int DELAY          = 1,
   parameter int WINDOW_SAMPLES = 1024,
   parameter int DECAY_CYCLES   = 1000000,
   parameter int HOLD_CYCLES    = 50000000
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              sample_valid,
   input  logic signed [15:0] sample_data,
   output logic              sample_ready,
   input  logic [15:0]       maxCount,
   output logic [15:0]       onCount,
   output logic [15:0]       peakCount,
   output logic              level_valid
);

   // A misconfigured instance never accepts samples.
   localparam bit CfgOk = (DELAY >= 0) && (WINDOW_SAMPLES >= 1) && (WINDOW_SAMPLES <= 65536);

   function automatic logic [MAG_W-1:0] magSat(input logic signed [15:0] s);
      logic signed [15:0] negS;
      negS = -s;
      if (s == 16'sh8000) return {MAG_W{1'b1}};
      if (s < 0)          return negS[MAG_W-1:0];
      return s[MAG_W-1:0];
   endfunction

   meterState_t       state, nextState;
   logic              clear, accept, lastSample, tick, holdExpired, holdRestart;
   logic [MAG_W-1:0]  sampMag, winPeak, peakWithSample;
   logic [16:0]       sampCnt;
   logic              mulStart, mulBusy, mulDone;
   logic [PROD_W-1:0] product;
   logic [LVL_W-1:0]  target, floorLvl, effFloor, onNext, peakNext;
   logic [31:0]       decayCnt, holdCnt;
   logic              unusedProdLsb;

   assign clear          = (state == IDLE) || !enable;
   assign sample_ready   = (state == ACCUM) && CfgOk;
   assign accept         = sample_valid && sample_ready;
   assign lastSample     = (sampCnt == 17'(WINDOW_SAMPLES - 1));
   assign sampMag        = magSat(sample_data);
   assign peakWithSample = (sampMag > winPeak) ? sampMag : winPeak;
   assign mulStart       = accept && lastSample;
   assign target         = product[PROD_W-1:MAG_W];
   assign unusedProdLsb  = ^product[MAG_W-1:0];
   assign tick           = (state != IDLE) && (decayCnt == 32'(DECAY_CYCLES - 1));
   assign holdExpired    = (holdCnt >= 32'(HOLD_CYCLES));

   ws2812b_meter_mul16 uMul (
      .clk          (clk),
      .reset_n      (reset_n),
      .clear        (clear),
      .start        (mulStart),
      .multiplicand (peakWithSample),
      .multiplier   (maxCount),
      .busy         (mulBusy),
      .done         (mulDone),
      .product      (product)
   );

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (enable) nextState = ACCUM;
         ACCUM:   if (mulStart) nextState = MAP;
         MAP:     if (mulDone || !mulBusy) nextState = UPDATE;
         UPDATE:  nextState = ACCUM;
         default: nextState = IDLE;
      endcase
      if (!enable) nextState = IDLE;
   end

   // Decay first, then attack, so an attack overrides a coincident tick.
   always_comb begin
      effFloor    = (state == UPDATE) ? target : floorLvl;
      onNext      = onCount;
      peakNext    = peakCount;
      holdRestart = 1'b0;
      if (tick && (onCount > effFloor)) onNext = onCount - 16'd1;
      if ((state == UPDATE) && (target >= onCount)) onNext = target;
      if (onNext > maxCount) onNext = maxCount;
      if (onNext > peakCount) begin
         peakNext    = onNext;
         holdRestart = 1'b1;
      end else if (holdExpired && tick && (peakCount > onNext)) begin
         peakNext = peakCount - 16'd1;
      end
      if (peakNext > maxCount) peakNext = maxCount;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nextState;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         winPeak <= '0;
         sampCnt <= '0;
      end else if (clear) begin
         winPeak <= '0;
         sampCnt <= '0;
      end else if (accept) begin
         winPeak <= lastSample ? '0 : peakWithSample;
         sampCnt <= lastSample ? '0 : sampCnt + 17'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         decayCnt    <= '0;
         holdCnt     <= '0;
         floorLvl    <= '0;
         onCount     <= '0;
         peakCount   <= '0;
         level_valid <= 1'b0;
      end else if (clear) begin
         decayCnt    <= '0;
         holdCnt     <= '0;
         floorLvl    <= '0;
         onCount     <= '0;
         peakCount   <= '0;
         level_valid <= 1'b0;
      end else begin
         decayCnt    <= tick ? '0 : decayCnt + 32'd1;
         holdCnt     <= holdRestart ? '0 : (holdExpired ? holdCnt : holdCnt + 32'd1);
         onCount     <= onNext;
         peakCount   <= peakNext;
         level_valid <= (state == UPDATE);
         if (state == UPDATE) floorLvl <= target;
      end
   end

endmodule

// File: tb/tb_ws2812b_meter_level.sv
// Directed bench for ws2812b_meter_level: window/MAP timing, attack, decay,
// peak hold, maxCount clamping and reset/enable behaviour.
module tb_ws2812b_meter_level;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              enable;
   logic              sample_valid;
   logic signed [15:0] sample_data;
   logic              sample_ready;
   logic [15:0]       maxCount;
   logic [15:0]       onCount;
   logic [15:0]       peakCount;
   logic              level_valid;

   int nVec = 0;
   int nBad = 0;
   int cyc  = 0;

   always #5 clk = ~clk;

   ws2812b_meter_level #(
      .DELAY          (1),
      .WINDOW_SAMPLES (4),
      .DECAY_CYCLES   (10),
      .HOLD_CYCLES    (50)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .sample_ready (sample_ready),
      .maxCount     (maxCount),
      .onCount      (onCount),
      .peakCount    (peakCount),
      .level_valid  (level_valid)
   );

   task automatic chkVec(input string tag, input int got, input int exp);
      nVec++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic sendSample(input logic signed [15:0] d);
      sample_valid = 1'b1;
      sample_data  = d;
      step();
      sample_valid = 1'b0;
      sample_data  = '0;
   endtask

   task automatic assertReset(input string tag);
      reset_n = 1'b0;
      #1;
      chkVec({tag, "_on"},    int'(onCount),      0);
      chkVec({tag, "_pk"},    int'(peakCount),    0);
      chkVec({tag, "_ready"}, int'(sample_ready), 0);
      chkVec({tag, "_vld"},   int'(level_valid),  0);
   endtask

   // Releases reset with enable high; cycle 0 is the first ACCUM cycle.
   task automatic releaseRun();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      enable  = 1'b1;
      @(posedge clk);
      #1;
      cyc = 0;
   endtask

   // Lit count after the zero window: floor drops to 0 at cycle 42, ticks end cycles 49, 59, ...
   function automatic int onModel(input int c);
      int v;
      if (c < 50) return 59;
      v = 59 - (c - 40) / 10;
      return (v < 0) ? 0 : v;
   endfunction

   // Peak marker set at cycle 20, hold expires at cycle 71, first decrement on the tick ending cycle 79.
   function automatic int pkModel(input int c);
      int v;
      if (c < 80) return 59;
      v = 59 - (c - 70) / 10;
      return (v < 0) ? 0 : v;
   endfunction

   initial begin
      reset_n      = 1'b1;
      enable       = 1'b0;
      sample_valid = 1'b0;
      sample_data  = '0;
      maxCount     = 16'd60;
      #2;

      // Full-scale window, then a silent window: MAP timing, decay and hold.
      assertReset("rst0");
      releaseRun();
      chkVec("ready_accum", int'(sample_ready), 1);
      sendSample(16'sd100);
      sendSample(16'sh8000);
      sendSample(16'sd5);
      sendSample(16'sd0);
      for (int i = 0; i < 16; i++) begin
         chkVec("ready_map", int'(sample_ready), 0);
         step();
      end
      chkVec("vld_early", int'(level_valid), 0);
      step();
      chkVec("vld_w1", int'(level_valid), 1);
      chkVec("on_w1", int'(onCount), 59);
      chkVec("pk_w1", int'(peakCount), 59);
      chkVec("ready_back", int'(sample_ready), 1);
      step();
      chkVec("vld_once", int'(level_valid), 0);
      for (int i = 0; i < 4; i++) sendSample(16'sd0);
      while (cyc < 43) step();
      chkVec("vld_w2", int'(level_valid), 1);
      while (cyc <= 700) begin
         chkVec("on_decay", int'(onCount), onModel(cyc));
         chkVec("pk_hold", int'(peakCount), pkModel(cyc));
         step();
      end

      // Attack on the same cycle as a decay tick.
      assertReset("rstB");
      releaseRun();
      sendSample(16'sd10923);
      for (int i = 0; i < 3; i++) sendSample(16'sd0);
      while (cyc < 21) step();
      chkVec("on_20", int'(onCount), 20);
      chkVec("pk_20", int'(peakCount), 20);
      while (cyc < 29) step();
      sendSample(16'sd21846);
      for (int i = 0; i < 3; i++) sendSample(16'sd0);
      while (cyc < 50) step();
      chkVec("vld_atk", int'(level_valid), 1);
      chkVec("on_atk", int'(onCount), 40);
      chkVec("pk_atk", int'(peakCount), 40);

      // Live maxCount clamping.
      sendSample(16'sh8000);
      for (int i = 0; i < 3; i++) sendSample(16'sd0);
      while (cyc < 71) step();
      chkVec("on_full", int'(onCount), 59);
      maxCount = 16'd10;
      step();
      chkVec("on_clamp", int'(onCount), 10);
      chkVec("pk_clamp", int'(peakCount), 10);
      maxCount = 16'd0;
      step();
      chkVec("on_max0", int'(onCount), 0);
      chkVec("pk_max0", int'(peakCount), 0);
      maxCount = 16'd60;
      step();

      // Reset in MAP cycle 8 discards the window in flight.
      sendSample(16'sh8000);
      for (int i = 0; i < 3; i++) sendSample(16'sd0);
      while (cyc < 95) step();
      chkVec("on_premap", int'(onCount), 59);
      sendSample(16'sh8000);
      for (int i = 0; i < 3; i++) sendSample(16'sd0);
      while (cyc < 106) step();
      assertReset("rstMap");
      releaseRun();
      while (cyc < 26) begin
         chkVec("vld_quiet", int'(level_valid), 0);
         sample_valid = (cyc >= 5) && (cyc <= 8);
         sample_data  = (cyc == 5) ? 16'sd8192 : 16'sd0;
         step();
      end
      sample_valid = 1'b0;
      sample_data  = '0;
      chkVec("vld_post", int'(level_valid), 1);
      chkVec("on_post", int'(onCount), 15);
      chkVec("pk_post", int'(peakCount), 15);

      // Dropping enable returns to IDLE with everything cleared.
      step();
      enable = 1'b0;
      step();
      chkVec("ready_idle", int'(sample_ready), 0);
      chkVec("on_idle", int'(onCount), 0);
      chkVec("pk_idle", int'(peakCount), 0);
      chkVec("vld_idle", int'(level_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

endmodule

// File: doc/ws2812b_meter_level.md
WS2812B_METER_LEVEL -- requirements
Module: ws2812b_meter_level

Interface
REQ-001 SHALL have parameter DELAY, default 1, simulation delay applied to every registered assignment.
REQ-002 SHALL have parameter WINDOW_SAMPLES, default 1024, samples per peak-detect window (range 1..65536).
REQ-003 SHALL have parameter DECAY_CYCLES, default 1000000, clk cycles per one-LED decay step (10 ms at 100 MHz).
REQ-004 SHALL have parameter HOLD_CYCLES, default 50000000, clk cycles the peak marker holds before decaying (0.5 s at 100 MHz).
REQ-005 SHALL have ports clk  input  1  system clock; reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port enable  input  1  block run enable.
REQ-007 SHALL have ports sample_valid  input  1, sample_data  input  16  signed PCM sample, sample_ready  output  1.
REQ-008 SHALL have port maxCount  input  16  total LED count.
REQ-009 SHALL have ports onCount  output  16  lit LED count; peakCount  output  16  peak-marker position; level_valid  output  1  one-cycle window-update pulse.

Function
REQ-010 SHALL accept a sample only on a clk edge with sample_valid=1 and sample_ready=1.
REQ-011 SHALL implement states IDLE, ACCUM, MAP, UPDATE; IDLE->ACCUM when enable=1; any state->IDLE on the edge after enable=0.
REQ-012 SHALL drive sample_ready=1 only in ACCUM.
REQ-013 SHALL compute the magnitude of each accepted sample as |sample_data|, with -32768 saturated to 32767 (15-bit result).
REQ-014 SHALL keep a window peak as the max of magnitudes and a sample counter; on the accept that brings the count to WINDOW_SAMPLES, SHALL latch the peak (including that sample), clear peak and counter, latch maxCount, and enter MAP.
REQ-015 In MAP, SHALL compute target = (peak * maxCount) >> 15 by 16-cycle sequential shift-add into a 31-bit product; target is the 16-bit field product[30:15]; MAP lasts exactly 16 cycles.
REQ-016 UPDATE SHALL last one cycle, pulse level_valid=1, store target as the decay floor, set onCount=target if target >= onCount, and return to ACCUM.
REQ-017 SHALL run a decay timer in every non-IDLE state; on each expiry (every DECAY_CYCLES cycles), SHALL decrement onCount by 1 if onCount > floor.
REQ-018 When a decay tick and an UPDATE attack (target >= onCount) coincide, the attack SHALL win; when UPDATE has target < onCount, the tick SHALL still apply.
REQ-019 When onCount > peakCount, SHALL set peakCount=onCount and restart the hold timer.
REQ-020 After HOLD_CYCLES without a restart, SHALL decrement peakCount by 1 per decay tick while peakCount > onCount.
REQ-021 If onCount or peakCount exceeds the live maxCount, SHALL clamp it to maxCount on the next edge; maxCount=0 forces both outputs to 0.
REQ-022 In IDLE, SHALL hold onCount, peakCount, floor, window peak, sample counter and all timers at 0, with level_valid=0.

Reset
REQ-023 On reset_n=0, SHALL asynchronously force state=IDLE, sample_ready=0, level_valid=0, onCount=0, peakCount=0, and clear all counters, timers and the product register.
REQ-024 A reset asserted mid-window or mid-MAP SHALL discard the partial result; no level_valid pulse SHALL follow reset release until a full window completes.

Structure
REQ-025 The state encodings and the MAP step count (16) SHALL live in a shared package ws2812b_meter_pkg, also usable by ws2812b_meter_ctrl.
REQ-026 The shift-add multiplier SHALL be one sub-module, ws2812b_meter_mul16 (start/busy/done handshake, 15x16 -> 31 bits).
REQ-027 onCount SHALL connect directly to the onCount input of ws2812b_meter_ctrl, with maxCount shared.

Verification
REQ-028 WINDOW_SAMPLES=4, maxCount=60, samples {100,-32768,5,0} -> sample_ready low for 16 cycles, then level_valid pulse with onCount=59 (32767*60>>15).
REQ-029 DECAY_CYCLES=10, onCount=59, next window all zeros -> onCount drops by 1 every 10 cycles to 0; never below 0.
REQ-030 HOLD_CYCLES=50, peak reaches 30 then level falls -> peakCount stays 30 for 50 cycles, then decrements one per tick, always >= onCount.
REQ-031 Decay expiry on the same cycle as UPDATE with target=40 > onCount=20 -> onCount=40, no decrement that cycle.
REQ-032 Reset pulse during MAP cycle 8 -> all outputs 0 immediately; after release with enable=1, the first level_valid follows only after 4 new samples plus 16 MAP cycles.
REQ-033 maxCount dropped from 60 to 10 while onCount=59 -> onCount=10 and peakCount<=10 on the next edge.
